// File: rtl/clockdivider_multi_pkg.sv
// Shared definitions for the multi-channel clock divider: channel state
// encodings and the default counter width.
package clockdivider_multi_pkg;

    typedef enum logic {
        CH_OFF = 1'b0,
        CH_RUN = 1'b1
    } ch_state_e;

    localparam int DEF_CNT_W = 25;

endpackage

// File: rtl/clockdivider_chan.sv
// One divider channel: programmable half-period counter with glitch-free
// reload, enable, phase restart and a rising-edge tick strobe.
module clockdivider_chan
    import clockdivider_multi_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DEF_HALF = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Sync,
    input  logic             Load,
    input  logic [CNT_W-1:0] LoadVal,
    output logic             ClkOut,
    output logic             Tick,
    output logic             Pend
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             pendv_q, pendv_d;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;
    logic             wrap;

    // >= rather than == keeps the counter from ever running past Active
    assign wrap = (cnt_q >= active_q);

    always_comb begin
        state_d   = En ? CH_RUN : CH_OFF;
        cnt_d     = cnt_q;
        active_d  = active_q;
        pending_d = pending_q;
        pendv_d   = pendv_q;
        clkout_d  = clkout_q;
        tick_d    = 1'b0;

        if (Sync) begin
            cnt_d    = '0;
            clkout_d = 1'b0;
            pendv_d  = 1'b0;
            if (Load)
                active_d = LoadVal;
            else if (pendv_q)
                active_d = pending_q;
        end else if (state_d == CH_OFF) begin
            cnt_d    = '0;
            clkout_d = 1'b0;
            if (Load) begin
                active_d = LoadVal;
                pendv_d  = 1'b0;
            end else if (pendv_q && state_q == CH_RUN) begin
                // first cycle after being disabled: retire the deferred reload
                active_d = pending_q;
                pendv_d  = 1'b0;
            end
        end else if (wrap) begin
            cnt_d    = '0;
            clkout_d = ~clkout_q;
            tick_d   = ~clkout_q;
            if (Load) begin
                active_d = LoadVal;
                pendv_d  = 1'b0;
            end else if (pendv_q) begin
                active_d = pending_q;
                pendv_d  = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (Load) begin
                pending_d = LoadVal;
                pendv_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= CH_OFF;
            cnt_q     <= '0;
            active_q  <= CNT_W'(DEF_HALF);
            pending_q <= '0;
            pendv_q   <= 1'b0;
            clkout_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pendv_q   <= pendv_d;
            clkout_q  <= clkout_d;
            tick_q    <= tick_d;
        end
    end

    assign ClkOut = clkout_q;
    assign Tick   = tick_q;
    assign Pend   = pendv_q;

endmodule

// File: rtl/clockdivider_multi.sv
// NUM_CH independent programmable clock dividers sharing one input clock,
// reset and phase-restart. ClkOut is fabric-only; use Tick as clock enable.
module clockdivider_multi
    import clockdivider_multi_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DEF_HALF = 10
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_CH-1:0]       En,
    input  logic                    Sync,
    input  logic [NUM_CH-1:0]       Load,
    input  logic [NUM_CH*CNT_W-1:0] LoadVal,
    output logic [NUM_CH-1:0]       ClkOut,
    output logic [NUM_CH-1:0]       Tick,
    output logic [NUM_CH-1:0]       Pend
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clockdivider_chan #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .Clk     (Clk),
            .Rst     (Rst),
            .En      (En[g]),
            .Sync    (Sync),
            .Load    (Load[g]),
            .LoadVal (LoadVal[g*CNT_W +: CNT_W]),
            .ClkOut  (ClkOut[g]),
            .Tick    (Tick[g]),
            .Pend    (Pend[g])
        );
    end

endmodule

// File: tb/tb_clockdivider_multi.sv
// Directed test-plan steps followed by randomized traffic, all checked
// every cycle against a half-period based model of each channel.
module tb_clockdivider_multi;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int DEF_HALF = 10;

    logic                    Clk = 1'b0;
    logic                    Rst = 1'b1;
    logic [NUM_CH-1:0]       En = '0;
    logic                    Sync = 1'b0;
    logic [NUM_CH-1:0]       Load = '0;
    logic [NUM_CH*CNT_W-1:0] LoadVal = '0;
    logic [NUM_CH-1:0]       ClkOut, Tick, Pend;

    int vectors = 0;
    int miscompares = 0;

    // model: elapsed cycles of current half, half-period, pending (-1 = none)
    int   m_el   [NUM_CH];
    int   m_half [NUM_CH];
    int   m_pend [NUM_CH];
    logic m_clk  [NUM_CH];
    logic m_tick [NUM_CH];

    clockdivider_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Sync(Sync), .Load(Load),
        .LoadVal(LoadVal), .ClkOut(ClkOut), .Tick(Tick), .Pend(Pend)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            int lv;
            lv = int'(LoadVal[c*CNT_W +: CNT_W]);
            m_tick[c] = 1'b0;
            if (Rst) begin
                m_el[c] = 0; m_half[c] = DEF_HALF; m_pend[c] = -1; m_clk[c] = 1'b0;
            end else if (Sync || !En[c]) begin
                m_el[c] = 0; m_clk[c] = 1'b0;
                if (Load[c]) m_half[c] = lv;
                else if (m_pend[c] >= 0) m_half[c] = m_pend[c];
                m_pend[c] = -1;
            end else if (m_el[c] + 1 == m_half[c] + 1) begin
                // this cycle completes a half-period of (half+1) cycles
                m_el[c] = 0;
                m_clk[c] = ~m_clk[c];
                m_tick[c] = m_clk[c];
                if (Load[c]) m_half[c] = lv;
                else if (m_pend[c] >= 0) m_half[c] = m_pend[c];
                m_pend[c] = -1;
            end else begin
                m_el[c]++;
                if (Load[c]) m_pend[c] = lv;
            end
        end
    endtask

    task automatic cyc();
        logic [NUM_CH-1:0] ec, et, ep;
        @(posedge Clk);
        model_step();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            ec[c] = m_clk[c]; et[c] = m_tick[c]; ep[c] = (m_pend[c] >= 0);
        end
        chk("clkout", int'(ClkOut), int'(ec));
        chk("tick", int'(Tick), int'(et));
        chk("pend", int'(Pend), int'(ep));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // period and high time measured from one Tick to the next
    task automatic measure(input int ch, output int per, output int hi);
        int t;
        t = 0;
        per = -1; hi = -1;
        while (!Tick[ch] && t < 300) begin cyc(); t++; end
        if (!Tick[ch]) return;
        hi = 1; t = 0;
        forever begin
            cyc(); t++;
            if (Tick[ch]) begin per = t; break; end
            if (t >= 600) break;
            if (ClkOut[ch]) hi++;
        end
    endtask

    task automatic set_lv(input int ch, input int v);
        LoadVal[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    initial begin
        int per, hi, t;
        for (int c = 0; c < NUM_CH; c++) begin
            m_el[c] = 0; m_half[c] = DEF_HALF; m_pend[c] = -1;
            m_clk[c] = 1'b0; m_tick[c] = 1'b0;
        end

        // reset state
        run(2);
        chk("rst_clkout", int'(ClkOut), 0);
        chk("rst_tick", int'(Tick), 0);
        chk("rst_pend", int'(Pend), 0);

        // default half-period on channel 0
        Rst = 1'b0; En = 4'b0001;
        measure(0, per, hi);
        chk("ch0_period", per, 22);
        chk("ch0_high", hi, 11);
        chk("ch0_others", int'(ClkOut[3:1]), 0);

        // deferred reload on channel 1 at Cnt=5
        En[1] = 1'b1;
        run(5);
        Load[1] = 1'b1; set_lv(1, 3);
        cyc();
        Load[1] = 1'b0;
        chk("ch1_pend_set", int'(Pend[1]), 1);
        measure(1, per, hi);
        chk("ch1_pend_clr", int'(Pend[1]), 0);
        chk("ch1_period", per, 8);
        chk("ch1_high", hi, 4);

        // load of 0 on a wrap cycle bypasses to Active
        t = 0;
        while (m_el[1] != m_half[1] && t < 100) begin cyc(); t++; end
        chk("ch1_wrap_found", int'(m_el[1] == m_half[1]), 1);
        Load[1] = 1'b1; set_lv(1, 0);
        cyc();
        Load[1] = 1'b0;
        chk("ch1_bypass_pend", int'(Pend[1]), 0);
        measure(1, per, hi);
        chk("ch1_h0_period", per, 2);
        chk("ch1_h0_high", hi, 1);

        // channels 2 and 3 started apart, then aligned by Sync
        En[2] = 1'b1; run(7);
        En[3] = 1'b1; run(20);
        Sync = 1'b1; cyc(); Sync = 1'b0;
        chk("sync_clkout", int'(ClkOut[3:2]), 0);
        for (int i = 0; i < 50; i++) begin
            cyc();
            chk("sync_align_clk", int'(ClkOut[3]), int'(ClkOut[2]));
            chk("sync_align_tick", int'(Tick[3]), int'(Tick[2]));
        end

        // disable mid-high with a pending load of 5, then restart
        t = 0;
        while (!Tick[0] && t < 100) begin cyc(); t++; end
        Load[0] = 1'b1; set_lv(0, 5);
        cyc();
        Load[0] = 1'b0;
        chk("ch0_pend5", int'(Pend[0]), 1);
        chk("ch0_high_phase", int'(ClkOut[0]), 1);
        En[0] = 1'b0; cyc();
        chk("ch0_off_clk", int'(ClkOut[0]), 0);
        chk("ch0_off_pend", int'(Pend[0]), 0);
        run(3);
        En[0] = 1'b1;
        t = 0;
        do begin cyc(); t++; end while (!Tick[0] && t < 100);
        chk("ch0_first_rise", t, 6);

        // reset mid-run discards a pending load
        run(2);
        Load[1] = 1'b1; set_lv(1, 7);
        if (m_el[1] == m_half[1]) cyc();
        cyc();
        Load[1] = 1'b0;
        Rst = 1'b1; cyc();
        chk("rst_mid_clk", int'(ClkOut), 0);
        chk("rst_mid_pend", int'(Pend), 0);
        Rst = 1'b0; En = 4'b1111;
        measure(1, per, hi);
        chk("post_rst_period", per, 22);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) En = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++) begin
                Load[c] = ($urandom_range(0, 7) == 0);
                set_lv(c, int'($urandom_range(0, 15)));
            end
            Sync = ($urandom_range(0, 99) == 0);
            Rst  = ($urandom_range(0, 299) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
